// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module      : mem_port_arbiter
// Description : Shares the single RV32I memory port between instruction fetch
//               and load/store, with anti-starvation for fetch and local
//               misalignment faulting for load/store.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   // instruction fetch port
   input  logic        if_req_valid,
   output logic        if_req_ready,
   input  logic [31:0] if_addr,
   output logic        if_resp_valid,
   output logic [31:0] if_rdata,
   // load/store port
   input  logic        ls_req_valid,
   output logic        ls_req_ready,
   input  logic        ls_we,
   input  logic [2:0]  ls_funct3,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_resp_valid,
   output logic [31:0] ls_rdata,
   output logic        ls_fault,
   // memory port
   output logic        mem_write_mem,
   output logic [2:0]  mem_funct3,
   output logic [31:0] mem_write_addr,
   output logic [31:0] mem_write_data,
   output logic [31:0] mem_read_addr,
   input  logic [31:0] mem_read_data
);

   localparam logic [3:0] STARVE_MAX   = 4'(STARVE_LIMIT);
   localparam logic [2:0] FUNCT3_WORD  = 3'b010;

   logic [3:0]  starve_cnt;
   logic [3:0]  starve_cnt_nxt;
   logic        starve_hit;
   logic        grant_ls;
   logic        grant_if;
   logic        misaligned;

   logic        tag_valid;
   logic        tag_is_ls;
   logic        tag_store;
   logic        tag_fault;

   logic [31:0] held_read_addr;
   logic [31:0] held_write_addr;
   logic [31:0] held_write_data;
   logic [2:0]  held_funct3;

   // Width comes from funct3[1:0]; the sign bit (funct3[2]) does not affect alignment.
   always_comb begin
      misaligned = 1'b0;
      case (ls_funct3[1:0])
         2'b10:   misaligned = (ls_addr[1:0] != 2'b00);
         2'b01:   misaligned = ls_addr[0];
         default: misaligned = 1'b0;
      endcase
   end

   // rst_n gates the grant so ready and the write strobe are low throughout reset.
   always_comb begin
      starve_hit = if_req_valid && (starve_cnt == STARVE_MAX);
      grant_ls   = rst_n && ls_req_valid && !starve_hit;
      grant_if   = rst_n && if_req_valid && !grant_ls;
   end

   assign ls_req_ready = grant_ls;
   assign if_req_ready = grant_if;

   always_comb begin
      starve_cnt_nxt = starve_cnt;
      if (!if_req_valid || grant_if) begin
         starve_cnt_nxt = 4'd0;
      end else if (grant_ls) begin
         starve_cnt_nxt = (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + 4'd1;
      end
   end

   // Memory drive: live values on a grant, otherwise the last granted values.
   always_comb begin
      mem_write_mem  = 1'b0;
      mem_funct3     = held_funct3;
      mem_read_addr  = held_read_addr;
      mem_write_addr = held_write_addr;
      mem_write_data = held_write_data;
      if (grant_ls) begin
         mem_write_mem  = ls_we && !misaligned;
         mem_funct3     = ls_funct3;
         mem_read_addr  = ls_addr;
         mem_write_addr = ls_addr;
         mem_write_data = ls_wdata;
      end else if (grant_if) begin
         mem_funct3     = FUNCT3_WORD;
         mem_read_addr  = if_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt      <= 4'd0;
         held_funct3     <= 3'd0;
         held_read_addr  <= 32'd0;
         held_write_addr <= 32'd0;
         held_write_data <= 32'd0;
      end else begin
         starve_cnt      <= starve_cnt_nxt;
         held_funct3     <= mem_funct3;
         held_read_addr  <= mem_read_addr;
         held_write_addr <= mem_write_addr;
         held_write_data <= mem_write_data;
      end
   end

   // One-deep tag: memory latency is fixed at one cycle, so no queue is needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid <= 1'b0;
         tag_is_ls <= 1'b0;
         tag_store <= 1'b0;
         tag_fault <= 1'b0;
      end else begin
         tag_valid <= grant_ls || grant_if;
         tag_is_ls <= grant_ls;
         tag_store <= grant_ls && ls_we;
         tag_fault <= grant_ls && misaligned;
      end
   end

   always_comb begin
      if_resp_valid = tag_valid && !tag_is_ls;
      if_rdata      = if_resp_valid ? mem_read_data : 32'd0;
      ls_resp_valid = tag_valid && tag_is_ls;
      ls_fault      = ls_resp_valid && tag_fault;
      ls_rdata      = (ls_resp_valid && !tag_store && !tag_fault) ? mem_read_data : 32'd0;
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter with a
//               byte-addressed one-cycle-latency memory model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req_valid = 1'b0;
   logic        if_req_ready;
   logic [31:0] if_addr = 32'd0;
   logic        if_resp_valid;
   logic [31:0] if_rdata;
   logic        ls_req_valid = 1'b0;
   logic        ls_req_ready;
   logic        ls_we = 1'b0;
   logic [2:0]  ls_funct3 = 3'd0;
   logic [31:0] ls_addr = 32'd0;
   logic [31:0] ls_wdata = 32'd0;
   logic        ls_resp_valid;
   logic [31:0] ls_rdata;
   logic        ls_fault;
   logic        mem_write_mem;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_write_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_addr;
   logic [31:0] mem_read_data;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [0:4095];

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
      .ls_funct3(ls_funct3), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata), .ls_fault(ls_fault),
      .mem_write_mem(mem_write_mem), .mem_funct3(mem_funct3),
      .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
      .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = i[7:0];
   end

   // Memory model: read sees contents before this edge's write.
   always @(posedge clk) begin
      logic [11:0] ra;
      logic [11:0] wa;
      ra = mem_read_addr[11:0];
      wa = mem_write_addr[11:0];
      case (mem_funct3)
         3'b000:  mem_read_data <= {{24{mem[ra][7]}}, mem[ra]};
         3'b100:  mem_read_data <= {24'd0, mem[ra]};
         3'b001:  mem_read_data <= {{16{mem[ra+12'd1][7]}}, mem[ra+12'd1], mem[ra]};
         3'b101:  mem_read_data <= {16'd0, mem[ra+12'd1], mem[ra]};
         default: mem_read_data <= {mem[ra+12'd3], mem[ra+12'd2], mem[ra+12'd1], mem[ra]};
      endcase
      if (mem_write_mem) begin
         mem[wa] <= mem_write_data[7:0];
         if (mem_funct3[1:0] != 2'b00) mem[wa+12'd1] <= mem_write_data[15:8];
         if (mem_funct3[1:0] == 2'b10) begin
            mem[wa+12'd2] <= mem_write_data[23:16];
            mem[wa+12'd3] <= mem_write_data[31:24];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ls_set(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
      ls_req_valid = v;
      ls_we        = we;
      ls_funct3    = f3;
      ls_addr      = a;
      ls_wdata     = wd;
      #1;
   endtask

   initial begin
      int n_if;
      int n_ls;
      // reset with both requests pending
      if_req_valid = 1'b1;
      ls_req_valid = 1'b1;
      ls_we        = 1'b1;
      ls_funct3    = 3'b010;
      cyc();
      cyc();
      check("rst_if_ready", {31'd0, if_req_ready}, 32'd0);
      check("rst_ls_ready", {31'd0, ls_req_ready}, 32'd0);
      check("rst_wmem", {31'd0, mem_write_mem}, 32'd0);
      check("rst_resp", {30'd0, if_resp_valid, ls_resp_valid}, 32'd0);
      check("rst_rdata", if_rdata | ls_rdata, 32'd0);
      if_req_valid = 1'b0;
      ls_set(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
      rst_n = 1'b1;
      cyc();

      // 1: IF only, back-to-back
      if_req_valid = 1'b1;
      if_addr      = 32'h0;
      #1;
      check("t1_ready0", {31'd0, if_req_ready}, 32'd1);
      check("t1_funct3", {29'd0, mem_funct3}, 32'd2);
      cyc();
      check("t1_resp0", {31'd0, if_resp_valid}, 32'd1);
      check("t1_rdata0", if_rdata, 32'h03020100);
      if_addr = 32'h4;
      #1;
      check("t1_raddr1", mem_read_addr, 32'h4);
      cyc();
      check("t1_resp1", {31'd0, if_resp_valid}, 32'd1);
      check("t1_rdata1", if_rdata, 32'h07060504);
      if_req_valid = 1'b0;
      cyc();
      check("t1_idle", {30'd0, if_resp_valid, ls_resp_valid}, 32'd0);
      check("t1_hold_raddr", mem_read_addr, 32'h4);

      // 2: sw then lw
      ls_set(1'b1, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
      check("t2_sw_ready", {31'd0, ls_req_ready}, 32'd1);
      check("t2_sw_wmem", {31'd0, mem_write_mem}, 32'd1);
      check("t2_sw_waddr", mem_write_addr, 32'h100);
      check("t2_sw_wdata", mem_write_data, 32'hDEADBEEF);
      cyc();
      check("t2_sw_ack", {30'd0, ls_resp_valid, ls_fault}, 32'b10);
      check("t2_sw_rdata", ls_rdata, 32'd0);
      ls_set(1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
      check("t2_lw_wmem", {31'd0, mem_write_mem}, 32'd0);
      cyc();
      check("t2_lw_resp", {30'd0, ls_resp_valid, ls_fault}, 32'b10);
      check("t2_lw_rdata", ls_rdata, 32'hDEADBEEF);
      ls_set(1'b0, 1'b0, 3'b010, 32'h0, 32'd0);
      cyc();

      // 3: contention, expected grants LLLLI LLLLI
      n_if = 0;
      n_ls = 0;
      if_req_valid = 1'b1;
      if_addr      = 32'h0;
      ls_set(1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("t3_grant%0d", i), {30'd0, ls_req_ready, if_req_ready},
               (i % 5 == 4) ? 32'b01 : 32'b10);
         cyc();
         if (if_resp_valid) begin
            n_if++;
            check($sformatf("t3_if_rdata%0d", i), if_rdata, 32'h03020100);
         end
         if (ls_resp_valid) begin
            n_ls++;
            check($sformatf("t3_ls_rdata%0d", i), ls_rdata, 32'hDEADBEEF);
         end
      end
      check("t3_n_if", n_if, 32'd2);
      check("t3_n_ls", n_ls, 32'd8);
      if_req_valid = 1'b0;
      ls_set(1'b0, 1'b0, 3'b010, 32'h0, 32'd0);
      cyc();

      // 4: lh aligned, lw and sw misaligned
      ls_set(1'b1, 1'b0, 3'b001, 32'h102, 32'd0);
      cyc();
      check("t4_lh_fault", {30'd0, ls_resp_valid, ls_fault}, 32'b10);
      check("t4_lh_rdata", ls_rdata, 32'hFFFFDEAD);
      ls_set(1'b1, 1'b0, 3'b010, 32'h102, 32'd0);
      check("t4_lw_ready", {31'd0, ls_req_ready}, 32'd1);
      cyc();
      check("t4_lw_fault", {30'd0, ls_resp_valid, ls_fault}, 32'b11);
      check("t4_lw_rdata", ls_rdata, 32'd0);
      ls_set(1'b1, 1'b1, 3'b010, 32'h102, 32'h11111111);
      check("t4_sw_wmem", {31'd0, mem_write_mem}, 32'd0);
      cyc();
      check("t4_sw_fault", {30'd0, ls_resp_valid, ls_fault}, 32'b11);
      ls_set(1'b1, 1'b1, 3'b001, 32'h101, 32'h2222);
      check("t4_sh_wmem", {31'd0, mem_write_mem}, 32'd0);
      cyc();
      check("t4_sh_fault", {31'd0, ls_fault}, 32'd1);
      ls_set(1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
      cyc();
      check("t4_mem_intact", ls_rdata, 32'hDEADBEEF);

      // 5: sb / lb / lbu
      ls_set(1'b1, 1'b1, 3'b000, 32'h203, 32'h00000080);
      check("t5_sb_wmem", {31'd0, mem_write_mem}, 32'd1);
      cyc();
      ls_set(1'b1, 1'b0, 3'b000, 32'h203, 32'd0);
      cyc();
      check("t5_lb", ls_rdata, 32'hFFFFFF80);
      ls_set(1'b1, 1'b0, 3'b100, 32'h203, 32'd0);
      cyc();
      check("t5_lbu", ls_rdata, 32'h00000080);

      // 6: reset right after a load grant
      ls_set(1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
      check("t6_grant", {31'd0, ls_req_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_no_resp", {30'd0, ls_resp_valid, if_resp_valid}, 32'd0);
      check("t6_rdata", ls_rdata | if_rdata, 32'd0);
      check("t6_ready", {31'd0, ls_req_ready}, 32'd0);
      check("t6_mem_addr", mem_read_addr | mem_write_addr | mem_write_data, 32'd0);
      check("t6_funct3", {28'd0, mem_write_mem, mem_funct3}, 32'd0);
      cyc();
      check("t6_no_resp_late", {31'd0, ls_resp_valid}, 32'd0);
      ls_set(1'b0, 1'b0, 3'b010, 32'h0, 32'd0);
      if_req_valid = 1'b1;
      if_addr      = 32'h4;
      rst_n        = 1'b1;
      #1;
      check("t6_first_grant", {31'd0, if_req_ready}, 32'd1);
      cyc();
      check("t6_if_resp", if_rdata, 32'h07060504);
      if_req_valid = 1'b0;
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
